sprite_parse_engine: RTL and testbench

- Per-line Y-parse engine. Walks the sprite attribute table in fast VRAM and evaluates each sprite's Y/size/chain word against the upcoming raster line.
- Writes the indices of matching sprites into the active list, at one sprite per clock.
- Parametrised successor to the fixed 381-sprite / 96-entry parser: configurable table size, list depth and lookahead.
- Adds an explicit state machine, a busy/done handshake, an active count output and optional double-buffered list banks.

---
 rtl/sprite_pkg.sv | 25 ++
 rtl/sprite_y_match.sv | 35 +++
 rtl/sprite_parse_engine.sv | 173 +++++++++++++++++
 tb/tb_sprite_parse_engine.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | sprite_pkg                                                             |
// | Shared attribute-word layout, parse FSM encoding and default constants |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
package sprite_pkg;

    localparam int Y_MSB     = 15;
    localparam int Y_LSB     = 7;
    localparam int CHAIN_BIT = 6;
    localparam int SIZE_MSB  = 5;

    localparam logic [10:0] TABLE_BASE_DEF = 11'h200;
    localparam int          LOOKAHEAD_DEF  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } parse_state_t;

endpackage
`default_nettype wire

// File: rtl/sprite_y_match.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | sprite_y_match                                                         |
// | Combinational Y/size test of one attribute word against the line       |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module sprite_y_match #(
    parameter int LOOKAHEAD = 2
) (
    input  logic [6:0] line,    // raster line bits [7:1]; bit 0 comes from flip
    input  logic       flip,
    input  logic [8:0] y,
    input  logic [5:0] size,
    output logic       match
);

    logic [7:0] w_l;
    logic [8:0] w_a;
    logic       w_n;
    logic [5:0] w_s;
    logic       w_unused_a_low;

    always_comb begin
        w_l   = 8'(LOOKAHEAD) + {line, flip};
        w_a   = {1'b0, w_l} + {1'b0, y[7:0]};
        w_n   = ~(w_a[8] ^ y[8]);
        // Carry into bit 5 means the line falls inside the sprite's tile span
        w_s   = {1'b0, w_n, ~w_a[7:4]} + {1'b0, size[4:0]};
        match = w_s[5] | size[5];
    end

    assign w_unused_a_low = ^w_a[3:0];

endmodule
`default_nettype wire

// File: rtl/sprite_parse_engine.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | sprite_parse_engine                                                    |
// | Per-line Y-parse of the sprite table into the active list.             |
// | Option macro: SPRITE_PARSE_DOUBLE_BUFFER_EN (toggle bank per line)     |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module sprite_parse_engine
    import sprite_pkg::*;
#(
    parameter int          NUM_SPRITES  = 381,
    parameter int          IDX_W        = 9,
    parameter int          ACTIVE_DEPTH = 96,
    parameter int          LIST_AW      = 7,
    parameter int          LOOKAHEAD    = LOOKAHEAD_DEF,
    parameter logic [10:0] TABLE_BASE   = TABLE_BASE_DEF
) (
    input  logic               PARSE_INDEX_INC_CLK,
    input  logic               RESETP,
    input  logic               NEW_LINE,
    input  logic [8:0]         RASTER_LINE,
    input  logic               FLIP,
    output logic [10:0]        TBL_ADDR,
    input  logic [15:0]        TBL_DATA,
    output logic               LIST_WE,
    output logic [LIST_AW:0]   LIST_ADDR,
    output logic [IDX_W-1:0]   LIST_DATA,
    output logic [LIST_AW:0]   ACTIVE_COUNT,
    output logic               BUSY,
    output logic               DONE,
    output logic               LIST_FULL,
    output logic               RD_BANK
);

    localparam logic [IDX_W-1:0] c_last_idx  = IDX_W'(NUM_SPRITES - 1);
    localparam logic [LIST_AW:0] c_depth_cnt = (LIST_AW + 1)'(ACTIVE_DEPTH);

    parse_state_t     state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [10:0]      tbl_addr_q, tbl_addr_d;
    logic             list_we_q, list_we_d;
    logic [LIST_AW:0] list_addr_q, list_addr_d;
    logic [IDX_W-1:0] list_data_q, list_data_d;
    logic [LIST_AW:0] count_q, count_d;
    logic             full_q, full_d;
    logic             chain_q, chain_d;
    logic [6:0]       line_q, line_d;
    logic             flip_q, flip_d;
    logic             bank_q, bank_d;
    logic             rd_bank_q, rd_bank_d;

    logic             w_match;
    logic             w_active;
    logic             w_unused_raster;

    sprite_y_match #(
        .LOOKAHEAD (LOOKAHEAD)
    ) u_y_match (
        .line  (line_q),
        .flip  (flip_q),
        .y     (TBL_DATA[Y_MSB:Y_LSB]),
        .size  (TBL_DATA[SIZE_MSB:0]),
        .match (w_match)
    );

    assign w_active        = TBL_DATA[CHAIN_BIT] ? chain_q : w_match;
    assign w_unused_raster = RASTER_LINE[8] ^ RASTER_LINE[0];

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        tbl_addr_d  = tbl_addr_q;
        list_we_d   = 1'b0;
        list_addr_d = list_addr_q;
        list_data_d = list_data_q;
        count_d     = count_q;
        full_d      = full_q;
        chain_d     = chain_q;
        line_d      = line_q;
        flip_d      = flip_q;
        bank_d      = bank_q;
        rd_bank_d   = rd_bank_q;

        if (NEW_LINE) begin
            // Restart wins over any write pending from the current evaluation
            state_d    = ST_PRIME;
            idx_d      = '0;
            tbl_addr_d = TABLE_BASE;
            count_d    = '0;
            full_d     = 1'b0;
            chain_d    = 1'b0;
            line_d     = RASTER_LINE[7:1];
            flip_d     = FLIP;
`ifdef SPRITE_PARSE_DOUBLE_BUFFER_EN
            bank_d     = ~bank_q;
`else
            bank_d     = FLIP;
`endif
            rd_bank_d  = ~bank_d;
        end else begin
            unique case (state_q)
                ST_PRIME: begin
                    tbl_addr_d = tbl_addr_q + 11'd1;
                    state_d    = ST_RUN;
                end
                ST_RUN: begin
                    chain_d = w_active;
                    if (w_active && !full_q) begin
                        list_we_d   = 1'b1;
                        list_addr_d = {bank_q, count_q[LIST_AW-1:0]};
                        list_data_d = idx_q;
                        count_d     = count_q + (LIST_AW + 1)'(1);
                        if (count_d == c_depth_cnt) begin
                            full_d = 1'b1;
                        end
                    end
                    if ((idx_q == c_last_idx) || full_d) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d      = idx_q + IDX_W'(1);
                        tbl_addr_d = tbl_addr_q + 11'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge PARSE_INDEX_INC_CLK or negedge RESETP) begin
        if (!RESETP) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            tbl_addr_q  <= TABLE_BASE;
            list_we_q   <= 1'b0;
            list_addr_q <= '0;
            list_data_q <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            chain_q     <= 1'b0;
            line_q      <= '0;
            flip_q      <= 1'b0;
            bank_q      <= 1'b0;
            rd_bank_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            tbl_addr_q  <= tbl_addr_d;
            list_we_q   <= list_we_d;
            list_addr_q <= list_addr_d;
            list_data_q <= list_data_d;
            count_q     <= count_d;
            full_q      <= full_d;
            chain_q     <= chain_d;
            line_q      <= line_d;
            flip_q      <= flip_d;
            bank_q      <= bank_d;
            rd_bank_q   <= rd_bank_d;
        end
    end

    assign TBL_ADDR     = tbl_addr_q;
    assign LIST_WE      = list_we_q;
    assign LIST_ADDR    = list_addr_q;
    assign LIST_DATA    = list_data_q;
    assign ACTIVE_COUNT = count_q;
    assign BUSY         = (state_q == ST_PRIME) || (state_q == ST_RUN);
    assign DONE         = (state_q == ST_DONE);
    assign LIST_FULL    = full_q;
    assign RD_BANK      = rd_bank_q;

endmodule
`default_nettype wire

// File: tb/tb_sprite_parse_engine.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_sprite_parse_engine                                                 |
// | Randomised and directed line parses checked against a list model       |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_sprite_parse_engine;

    localparam int          NUM   = 381;
    localparam int          DEPTH = 96;
    localparam int          LOOK  = 2;
    localparam logic [10:0] BASE  = 11'h200;

    logic        clk      = 1'b0;
    logic        rstn     = 1'b0;
    logic        new_line = 1'b0;
    logic [8:0]  raster   = '0;
    logic        flip     = 1'b0;
    logic [15:0] tbl_data = '0;
    logic [10:0] tbl_addr;
    logic        list_we;
    logic [7:0]  list_addr;
    logic [8:0]  list_data;
    logic [7:0]  active_count;
    logic        busy, done, list_full, rd_bank;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] attr [NUM];
    int          exp_q [$];
    bit          bank_m = 1'b0;

    always #5 clk = ~clk;

    sprite_parse_engine #(
        .NUM_SPRITES  (NUM),
        .IDX_W        (9),
        .ACTIVE_DEPTH (DEPTH),
        .LIST_AW      (7),
        .LOOKAHEAD    (LOOK),
        .TABLE_BASE   (BASE)
    ) dut (
        .PARSE_INDEX_INC_CLK (clk),
        .RESETP              (rstn),
        .NEW_LINE            (new_line),
        .RASTER_LINE         (raster),
        .FLIP                (flip),
        .TBL_ADDR            (tbl_addr),
        .TBL_DATA            (tbl_data),
        .LIST_WE             (list_we),
        .LIST_ADDR           (list_addr),
        .LIST_DATA           (list_data),
        .ACTIVE_COUNT        (active_count),
        .BUSY                (busy),
        .DONE                (done),
        .LIST_FULL           (list_full),
        .RD_BANK             (rd_bank)
    );

    // Fast VRAM: one clock read latency
    always @(posedge clk) begin : g_vram
        int off;
        off = int'(tbl_addr) - int'(BASE);
        tbl_data <= (off >= 0 && off < NUM) ? attr[off] : 16'h0;
    end

    initial begin : g_watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit model_match(input int rl, input bit fl, input logic [15:0] w);
        int l, y, a, n, s;
        l = (LOOK + ((rl / 2) % 128) * 2 + int'(fl)) % 256;
        y = int'(w[15:7]);
        a = l + (y % 256);
        n = ((a >= 256) == (y >= 256)) ? 1 : 0;
        s = n * 16 + (15 - (a % 256) / 16) + int'(w[4:0]);
        return (w[5] == 1'b1) || (s >= 32);
    endfunction

    task automatic build_expect(input int rl, input bit fl);
        bit cf, act;
        exp_q.delete();
        cf = 1'b0;
        for (int i = 0; i < NUM; i++) begin
            act = attr[i][6] ? cf : model_match(rl, fl, attr[i]);
            cf  = act;
            if (act) exp_q.push_back(i);
            if (exp_q.size() == DEPTH) break;
        end
    endtask

    task automatic clear_table();
        for (int i = 0; i < NUM; i++) attr[i] = 16'h0;
    endtask

    task automatic fill_random(input int max_size);
        for (int i = 0; i < NUM; i++) begin
            attr[i][15:7] = 9'($urandom);
            attr[i][6]    = ($urandom_range(0, 3) == 0);
            attr[i][5]    = ($urandom_range(0, 15) == 0);
            attr[i][4:0]  = 5'($urandom_range(0, max_size));
        end
    endtask

    task automatic update_bank(input bit fl);
`ifdef SPRITE_PARSE_DOUBLE_BUFFER_EN
        bank_m = ~bank_m;
`else
        bank_m = fl;
`endif
    endtask

    // Leaves the bench at the first negedge after the NEW_LINE edge
    task automatic start_line(input int rl, input bit fl);
        @(negedge clk);
        new_line = 1'b1;
        raster   = 9'(rl);
        flip     = fl;
        @(posedge clk);
        update_bank(fl);
        @(negedge clk);
        new_line = 1'b0;
        raster   = 9'($urandom);
        flip     = 1'($urandom);
    endtask

    task automatic collect_line(input int rl, input bit fl);
        int got, c, last_eval, exp_done;
        bit fin, exp_rd;
        build_expect(rl, fl);
        last_eval = (exp_q.size() == DEPTH) ? exp_q[DEPTH-1] : NUM - 1;
        exp_done  = last_eval + 2;
        exp_rd    = ~bank_m;
        got = 0;
        c   = 0;
        fin = 1'b0;
        while (!fin && c <= NUM + 8) begin
            if (list_we === 1'b1) begin
                if (got < exp_q.size()) begin
                    chk("wr_data", list_data, exp_q[got]);
                    chk("wr_addr", list_addr, {bank_m, 7'(got)});
                    chk("wr_cycle", c, exp_q[got] + 2);
                end else begin
                    chk("extra_write", got, exp_q.size());
                end
                got++;
            end
            if (done === 1'b1) begin
                fin = 1'b1;
            end else begin
                chk("busy_run", busy, 1);
                chk("tbl_addr_run", tbl_addr, int'(BASE) + c);
                @(negedge clk);
                c++;
            end
        end
        chk("done_cycle", c, exp_done);
        chk("n_writes", got, exp_q.size());
        chk("active_count", active_count, exp_q.size());
        chk("list_full", list_full, exp_q.size() == DEPTH);
        chk("busy_done", busy, 0);
        chk("rd_bank", rd_bank, exp_rd);
        chk("tbl_addr_hold", tbl_addr, int'(BASE) + last_eval + 1);
        @(negedge clk);
        chk("we_after_done", list_we, 0);
        chk("done_sticky", done, 1);
    endtask

    task automatic run_line(input int rl, input bit fl);
        start_line(rl, fl);
        collect_line(rl, fl);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_tbl_addr"}, tbl_addr, BASE);
        chk({tag, "_we"}, list_we, 0);
        chk({tag, "_laddr"}, list_addr, 0);
        chk({tag, "_ldata"}, list_data, 0);
        chk({tag, "_count"}, active_count, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_full"}, list_full, 0);
        chk({tag, "_rd_bank"}, rd_bank, 1);
    endtask

    task automatic abort_test();
        int pre, rl2;
        bit fl2, exp_rd;
        clear_table();
        for (int i = 198; i <= 202; i++) attr[i] = {9'($urandom), 1'b0, 6'h20};
        start_line(100, 1'b1);
        pre = 0;
        for (int c = 0; c <= 201; c++) begin
            if (list_we === 1'b1) pre++;
            if (c != 201) @(negedge clk);
        end
        chk("pre_abort_writes", pre, 2);
        rl2      = 37;
        fl2      = 1'b0;
        new_line = 1'b1;
        raster   = 9'(rl2);
        flip     = fl2;
        @(posedge clk);
        update_bank(fl2);
        @(negedge clk);
        new_line = 1'b0;
        exp_rd   = ~bank_m;
        chk("abort_we", list_we, 0);
        chk("abort_count", active_count, 0);
        chk("abort_done", done, 0);
        chk("abort_busy", busy, 1);
        chk("abort_rd_bank", rd_bank, exp_rd);
        collect_line(rl2, fl2);
    endtask

    task automatic reset_mid_run();
        for (int i = 0; i < NUM; i++) attr[i] = {9'($urandom), 1'b0, 6'h20};
        start_line(200, 1'b1);
        repeat (40) @(negedge clk);
        chk("pre_reset_we", list_we, 1);
        #2 rstn = 1'b0;
        #1 check_reset_values("rst_async");
        @(posedge clk);
        #1 check_reset_values("rst_held");
        @(negedge clk);
        rstn   = 1'b1;
        bank_m = 1'b0;
    endtask

    initial begin
        int rl;
        bit fl;
        clear_table();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rstn = 1'b1;

        // Single matching sprite at index 5
        clear_table();
        attr[5] = {9'h1FE, 1'b0, 6'd1};
        run_line(0, 1'b0);

        // Chain run 10..13 plus an orphan chain word at index 0
        clear_table();
        attr[0]  = {9'h000, 1'b1, 6'd0};
        attr[10] = {9'h000, 1'b0, 6'h20};
        for (int i = 11; i <= 13; i++) attr[i] = {9'h000, 1'b1, 6'd0};
        run_line(0, 1'b0);

        // Every sprite forced active: list fills at 96
        for (int i = 0; i < NUM; i++) attr[i] = {9'($urandom), 1'b0, 6'h20};
        run_line(50, 1'b0);

        // Tile boundary with flip set, L = 0x13
        clear_table();
        attr[20] = {9'h1ED, 1'b0, 6'd0};
        attr[21] = {9'h1ED, 1'b0, 6'd1};
        attr[22] = {9'h1DD, 1'b0, 6'd1};
        attr[23] = {9'h1FD, 1'b0, 6'd1};
        attr[24] = {9'h1FD, 1'b0, 6'd2};
        attr[25] = {9'h1FC, 1'b0, 6'd1};
        attr[26] = {9'h1EC, 1'b0, 6'd1};
        run_line(9'h10, 1'b1);

        for (int k = 0; k < 5; k++) begin
            fill_random((k == 4) ? 31 : 4);
            rl = $urandom_range(0, 511);
            fl = 1'($urandom);
            run_line(rl, fl);
        end

        abort_test();
        reset_mid_run();

        fill_random(4);
        rl = $urandom_range(0, 511);
        fl = 1'($urandom);
        run_line(rl, fl);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
